// File: rtl/timer_pkg.sv
// Shared timer definitions: field widths, default terminal values and the
// controller state encoding. Imported by the controller and by timer_counter.
package timer_pkg;

  localparam int MS_W  = 10;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam int MS_MAX_DEF  = 999;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;
  localparam int HR_MAX_DEF  = 23;

  // Controller state encoding (owned by the controller, shared here so both
  // sides and any checkers agree on the values).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_RUN     = 3'd4,
    ST_PAUSE   = 3'd5,
    ST_DONE    = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/timer_counter_if.sv
// Controller <-> counter datapath bundle. Not a valid/ready handshake: the
// step strobes are single-cycle level requests consumed on every rising
// clock edge, and the borrow flags answer them combinationally in the same
// cycle so the controller can chain field decrements.
interface timer_counter_if;
  import timer_pkg::*;

  logic             i_clear;
  logic             i_ms_up;
  logic             i_ms_down;
  logic             i_sec_up;
  logic             i_sec_down;
  logic             i_min_up;
  logic             i_min_down;
  logic             i_hr_up;
  logic             i_hr_down;
  logic [MS_W-1:0]  o_ms;
  logic [SEC_W-1:0] o_sec;
  logic [MIN_W-1:0] o_min;
  logic [HR_W-1:0]  o_hr;
  logic             o_ms_borrowdown;
  logic             o_sec_borrowdown;
  logic             o_min_borrowdown;
  logic             o_hr_borrowdown;

  modport master (
    output i_clear, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    input  o_ms, o_sec, o_min, o_hr,
           o_ms_borrowdown, o_sec_borrowdown, o_min_borrowdown, o_hr_borrowdown
  );

  modport slave (
    input  i_clear, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    output o_ms, o_sec, o_min, o_hr,
           o_ms_borrowdown, o_sec_borrowdown, o_min_borrowdown, o_hr_borrowdown
  );

endinterface

// File: rtl/mod_updown_counter.sv
// Generic modulo up/down counter, range 0..MAX. Up wraps to 0 without carry;
// down at 0 wraps to MAX (or holds 0 while sat_hold is high) and raises the
// combinational borrow flag.
module mod_updown_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             up,
  input  logic             down,
  input  logic             sat_hold,
  output logic [WIDTH-1:0] count,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] MAX_T = WIDTH'(MAX);

  // Field register: clear > both strobes > up > down > hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (up && down) begin
      count <= '0;
    end else if (up) begin
      // >= so that an out-of-range value also steps to 0
      count <= (count >= MAX_T) ? '0 : count + WIDTH'(1);
    end else if (down) begin
      if (count == '0) count <= sat_hold ? '0 : MAX_T;
      else             count <= count - WIDTH'(1);
    end
  end

  // Borrow: a lone down step taken from zero, same cycle as the strobe.
  always_comb begin
    borrow = down && !up && !clear && (count == '0);
  end

endmodule

// File: rtl/timer_counter.sv
// Countdown timer datapath: ms/sec/min/hr fields built from four modulo
// up/down counters. Optional build macro TIMER_COUNTER_SATURATE_EN makes a
// down step at 0:00:00.000 hold at zero with all borrows suppressed, and
// stops hours wrapping below zero.
module timer_counter
  import timer_pkg::*;
#(
  parameter int MS_MAX  = MS_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int HR_MAX  = HR_MAX_DEF   // must be <= 31
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  timer_counter_if.slave bus
);

  logic [MS_W-1:0]  ms_q;
  logic [SEC_W-1:0] sec_q;
  logic [MIN_W-1:0] min_q;
  logic [HR_W-1:0]  hr_q;
  logic ms_b, sec_b, min_b, hr_b;
  logic sat_all, sat_hr, borrow_en;

`ifdef TIMER_COUNTER_SATURATE_EN
  // Saturation: zero time is a floor; hours never wrap below zero.
  always_comb begin
    sat_all   = (ms_q == '0) && (sec_q == '0) && (min_q == '0) && (hr_q == '0);
    sat_hr    = (hr_q == '0);
    borrow_en = !sat_all;
  end
`else
  // Plain modulo wrap: no holding, borrows always visible.
  always_comb begin
    sat_all   = 1'b0;
    sat_hr    = 1'b0;
    borrow_en = 1'b1;
  end
`endif

  mod_updown_counter #(.WIDTH(MS_W), .MAX(MS_MAX)) u_ms (
    .clk(i_clk), .rstn(i_rstn), .clear(bus.i_clear),
    .up(bus.i_ms_up), .down(bus.i_ms_down), .sat_hold(sat_all),
    .count(ms_q), .borrow(ms_b)
  );

  mod_updown_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(i_clk), .rstn(i_rstn), .clear(bus.i_clear),
    .up(bus.i_sec_up), .down(bus.i_sec_down), .sat_hold(sat_all),
    .count(sec_q), .borrow(sec_b)
  );

  mod_updown_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(i_clk), .rstn(i_rstn), .clear(bus.i_clear),
    .up(bus.i_min_up), .down(bus.i_min_down), .sat_hold(sat_all),
    .count(min_q), .borrow(min_b)
  );

  mod_updown_counter #(.WIDTH(HR_W), .MAX(HR_MAX)) u_hr (
    .clk(i_clk), .rstn(i_rstn), .clear(bus.i_clear),
    .up(bus.i_hr_up), .down(bus.i_hr_down), .sat_hold(sat_hr),
    .count(hr_q), .borrow(hr_b)
  );

  // Drive the bundle: counts straight from the field flops, borrows gated.
  always_comb begin
    bus.o_ms             = ms_q;
    bus.o_sec            = sec_q;
    bus.o_min            = min_q;
    bus.o_hr             = hr_q;
    bus.o_ms_borrowdown  = ms_b  && borrow_en;
    bus.o_sec_borrowdown = sec_b && borrow_en;
    bus.o_min_borrowdown = min_b && borrow_en;
    bus.o_hr_borrowdown  = hr_b  && borrow_en;
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed plan steps followed by random strobes,
// all checked against a field-level arithmetic model.
module tb_timer_counter;

  logic i_clk;
  logic i_rstn;

  timer_counter_if bus();

  timer_counter dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .bus   (bus)
  );

`ifdef TIMER_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model: index 0=ms 1=sec 2=min 3=hr
  int model_v[4];
  logic [26:0] exp_q[$];

  // clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int max_of(input int f);
    case (f)
      0:       return 999;
      1:       return 59;
      2:       return 59;
      default: return 23;
    endcase
  endfunction

  function automatic bit all_zero();
    return (model_v[0] == 0) && (model_v[1] == 0) && (model_v[2] == 0) && (model_v[3] == 0);
  endfunction

  function automatic int next_val(input int f, input bit clr, input bit u, input bit d);
    int m;
    m = max_of(f);
    if (clr)    return 0;
    if (u && d) return 0;
    if (u)      return (model_v[f] + 1) % (m + 1);
    if (d) begin
      if (SAT && all_zero()) return 0;
      if (SAT && f == 3 && model_v[f] == 0) return 0;
      return (model_v[f] + m) % (m + 1);
    end
    return model_v[f];
  endfunction

  function automatic bit exp_borrow(input int f, input bit clr, input bit u, input bit d);
    return d && !u && !clr && (model_v[f] == 0) && !(SAT && all_zero());
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_strobes(input bit clr, input bit [3:0] up, input bit [3:0] dn);
    bus.i_clear    = clr;
    bus.i_ms_up    = up[0]; bus.i_ms_down  = dn[0];
    bus.i_sec_up   = up[1]; bus.i_sec_down = dn[1];
    bus.i_min_up   = up[2]; bus.i_min_down = dn[2];
    bus.i_hr_up    = up[3]; bus.i_hr_down  = dn[3];
  endtask

  task automatic check_counts(input string tag, input logic [26:0] e);
    check({tag, "_hr"},  32'(bus.o_hr),  32'(e[26:22]));
    check({tag, "_min"}, 32'(bus.o_min), 32'(e[21:16]));
    check({tag, "_sec"}, 32'(bus.o_sec), 32'(e[15:10]));
    check({tag, "_ms"},  32'(bus.o_ms),  32'(e[9:0]));
  endtask

  // One strobe cycle: borrows checked in the strobe cycle, counts one edge later.
  task automatic drive(input string tag, input bit clr, input bit [3:0] up, input bit [3:0] dn);
    int nv[4];
    bit eb[4];
    @(negedge i_clk);
    set_strobes(clr, up, dn);
    #1;
    for (int f = 0; f < 4; f++) begin
      eb[f] = exp_borrow(f, clr, up[f], dn[f]);
      nv[f] = next_val(f, clr, up[f], dn[f]);
    end
    check({tag, "_ms_borrow"},  32'(bus.o_ms_borrowdown),  32'(eb[0]));
    check({tag, "_sec_borrow"}, 32'(bus.o_sec_borrowdown), 32'(eb[1]));
    check({tag, "_min_borrow"}, 32'(bus.o_min_borrowdown), 32'(eb[2]));
    check({tag, "_hr_borrow"},  32'(bus.o_hr_borrowdown),  32'(eb[3]));
    exp_q.push_back({5'(nv[3]), 6'(nv[2]), 6'(nv[1]), 10'(nv[0])});
    @(posedge i_clk);
    #1;
    check_counts(tag, exp_q.pop_front());
    for (int f = 0; f < 4; f++) model_v[f] = nv[f];
    set_strobes(1'b0, 4'b0, 4'b0);
  endtask

  // Load a time by clearing and then stepping fields up together.
  task automatic set_time(input int h, input int m, input int s, input int ms);
    int n;
    drive("load_clr", 1'b1, 4'b0, 4'b0);
    n = ms;
    if (s > n) n = s;
    if (m > n) n = m;
    if (h > n) n = h;
    for (int i = 0; i < n; i++)
      drive("load", 1'b0, {i < h, i < m, i < s, i < ms}, 4'b0);
  endtask

  initial begin
    bit [3:0] ru, rd;
    bit rc;
    set_strobes(1'b0, 4'b0, 4'b0);
    for (int f = 0; f < 4; f++) model_v[f] = 0;

    // reset
    i_rstn = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_counts("reset", 27'd0);
    check("reset_ms_borrow", 32'(bus.o_ms_borrowdown), 32'd0);
    check("reset_hr_borrow", 32'(bus.o_hr_borrowdown), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // three ms down pulses from zero
    for (int i = 0; i < 3; i++) drive("ms_down", 1'b0, 4'b0000, 4'b0001);
    check("ms_after_3_down", 32'(bus.o_ms), SAT ? 32'd0 : 32'd997);

    // full chained roll 1:00:00.000 -> 0:59:59.999
    set_time(1, 0, 0, 0);
    drive("roll", 1'b0, 4'b0000, 4'b1111);
    check_counts("roll_abs", {5'd0, 6'd59, 6'd59, 10'd999});

    // sec wrap up without carry, then sec down from zero
    set_time(0, 5, 59, 0);
    drive("sec_up_wrap", 1'b0, 4'b0010, 4'b0000);
    check_counts("sec_up_abs", {5'd0, 6'd5, 6'd0, 10'd0});
    drive("sec_down_wrap", 1'b0, 4'b0000, 4'b0010);

    // both ms strobes zero the field; clear beats hr up
    set_time(0, 0, 0, 500);
    drive("ms_both", 1'b0, 4'b0001, 4'b0001);
    set_time(5, 0, 0, 0);
    drive("clear_prio", 1'b1, 4'b1000, 4'b0000);

    // all zero + ms down
    drive("zero_clr", 1'b1, 4'b0, 4'b0);
    drive("all_zero_down", 1'b0, 4'b0000, 4'b0001);

    // hr down from 0 with other fields nonzero
    set_time(0, 1, 0, 0);
    drive("hr_down_zero", 1'b0, 4'b0000, 4'b1000);

    // asynchronous reset mid-count
    set_time(2, 13, 7, 450);
    @(negedge i_clk);
    set_strobes(1'b0, 4'b0001, 4'b0000);
    #2 i_rstn = 1'b0;
    #1;
    check_counts("async_rst", 27'd0);
    check("async_rst_ms_borrow", 32'(bus.o_ms_borrowdown), 32'd0);
    for (int f = 0; f < 4; f++) model_v[f] = 0;
    set_strobes(1'b0, 4'b0, 4'b0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // random strobes
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 15) == 0);
      ru = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) ru = 4'b0;
      drive("rand", rc, ru, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
